// File: rtl/ex_alu_stage_pkg.sv
// Shared types and constants for the 16-bit execute-stage ALU.
// Opcode map, operand-invert decode and the raw beat carried in the skid entry.
package ex_alu_stage_pkg;

    localparam int WIDTH = 16;
    localparam int TAG_W = 3;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_NOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_NAND = 3'b110;
    localparam logic [2:0] ALU_XOR  = 3'b111;

    typedef struct packed {
        logic inv_x;
        logic inv_y;
        logic cin;
    } inv_t;

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
    } beat_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
    } flags_t;

    function automatic inv_t alu_inv(input logic [2:0] op);
        inv_t r;
        r = '0;
        unique case (op)
            ALU_SUB, ALU_SLT:  r = '{inv_x: 1'b0, inv_y: 1'b1, cin: 1'b1};
            ALU_NOR, ALU_NAND: r = '{inv_x: 1'b1, inv_y: 1'b1, cin: 1'b0};
            default:           r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_alu_stage_operand_invert_mux.sv
// Selects an ALU operand or its bitwise complement.
// One instance per operand feeds the shared adder/logic unit.
module operand_invert_mux #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic         sel,
    output logic [W-1:0] y
);

    assign y = sel ? ~a : a;

endmodule

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU: operand invert, add/logic/slt, flags,
// registered output with a one-entry skid buffer on a valid/ready link.
module ex_alu_stage
    import ex_alu_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf
);

    beat_t            skid_q, skid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    flags_t           flags_q, flags_d;
    logic             in_ready_q, in_ready_d;

    beat_t            in_beat;
    beat_t            sel_beat;
    inv_t             inv;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [WIDTH:0]   sum;
    logic             ovf_raw;
    logic [WIDTH-1:0] alu_res;
    flags_t           alu_flags;
    logic             in_fire;
    logic             out_free;

    assign in_beat.x   = in_x;
    assign in_beat.y   = in_y;
    assign in_beat.op  = in_op;
    assign in_beat.tag = in_tag;

    // The skid entry is older than anything on the input, so it computes first.
    assign sel_beat = skid_valid_q ? skid_q : in_beat;
    assign inv      = alu_inv(sel_beat.op);

    operand_invert_mux #(.W(WIDTH)) u_mux_x (
        .a   (sel_beat.x),
        .sel (inv.inv_x),
        .y   (xs)
    );

    operand_invert_mux #(.W(WIDTH)) u_mux_y (
        .a   (sel_beat.y),
        .sel (inv.inv_y),
        .y   (ys)
    );

    assign sum = {1'b0, xs} + {1'b0, ys}
               + {{WIDTH{1'b0}}, inv.cin};

    assign ovf_raw = (xs[WIDTH-1] == ys[WIDTH-1])
                   & (sum[WIDTH-1] != xs[WIDTH-1]);

    always_comb begin
        alu_res         = sum[WIDTH-1:0];
        alu_flags       = '0;
        unique case (sel_beat.op)
            ALU_ADD, ALU_SUB: begin
                alu_res         = sum[WIDTH-1:0];
                alu_flags.carry = sum[WIDTH];
                alu_flags.ovf   = ovf_raw;
            end
            ALU_AND:  alu_res = sel_beat.x & sel_beat.y;
            ALU_OR:   alu_res = sel_beat.x | sel_beat.y;
            ALU_NOR:  alu_res = xs & ys;
            ALU_NAND: alu_res = xs | ys;
            ALU_XOR:  alu_res = sel_beat.x ^ sel_beat.y;
            ALU_SLT: begin
                alu_res       = {{(WIDTH-1){1'b0}},
                                 sum[WIDTH-1] ^ ovf_raw};
                alu_flags.ovf = ovf_raw;
            end
            default: alu_res = sum[WIDTH-1:0];
        endcase
        alu_flags.zero = (alu_res == '0);
    end

    assign in_fire  = in_valid & in_ready_q;
    assign out_free = ~out_valid_q | out_ready;

    always_comb begin
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        flags_d      = flags_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q || in_fire) begin
                out_valid_d  = 1'b1;
                out_result_d = alu_res;
                out_tag_d    = sel_beat.tag;
                flags_d      = alu_flags;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
        // Ready drops one cycle behind a stall, leaving room for one skid beat.
        in_ready_d = flush
                   | (~skid_valid_d & ~(out_valid_q & ~out_ready));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            flags_q      <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            flags_q      <= flags_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign out_zero   = flags_q.zero;
    assign out_carry  = flags_q.carry;
    assign out_ovf    = flags_q.ovf;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Scoreboard bench for ex_alu_stage: directed ALU vectors,
// stall/skid streaming, flush and mid-stall reset.
module tb_ex_alu_stage;
    import ex_alu_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic [2:0]  in_op;
    logic [2:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_tag;
    logic        out_zero;
    logic        out_carry;
    logic        out_ovf;

    always #5 clk = ~clk;

    ex_alu_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_zero   (out_zero),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf)
    );

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  tag;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   accepted = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send(input logic [2:0] op,
                        input logic [15:0] x,
                        input logic [15:0] y,
                        input logic [2:0] tag,
                        input logic [15:0] res,
                        input logic z,
                        input logic c,
                        input logic v);
        int   n;
        exp_t e;
        n        = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_x     = x;
        in_y     = y;
        in_tag   = tag;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("send_ready_wait", {31'b0, in_ready}, 32'd1);
        if (in_ready) begin
            e.res = res;
            e.tag = tag;
            e.z   = z;
            e.c   = c;
            e.v   = v;
            sb.push_back(e);
            @(posedge clk);
            #1;
            accepted++;
        end
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t act;
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            act.res = out_result;
            act.tag = out_tag;
            act.z   = out_zero;
            act.c   = out_carry;
            act.v   = out_ovf;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat actual=%h required=none",
                         act);
            end else begin
                e = sb.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL beat_tag%0d actual=%h required=%h",
                             e.tag, act, e);
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_op     = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", {16'b0, out_result}, 32'd0);
        check("rst_tag", {29'b0, out_tag}, 32'd0);
        check("rst_flags", {29'b0, out_zero, out_carry, out_ovf}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_ready", {31'b0, in_ready}, 32'd1);

        out_ready = 1'b1;
        send(ALU_ADD,  16'h7FFF, 16'h0001, 3'd0, 16'h8000, 0, 0, 1);
        send(ALU_ADD,  16'hFFFF, 16'h0001, 3'd1, 16'h0000, 1, 1, 0);
        send(ALU_SUB,  16'h0005, 16'h0005, 3'd2, 16'h0000, 1, 1, 0);
        send(ALU_SUB,  16'h0003, 16'h0005, 3'd3, 16'hFFFE, 0, 0, 0);
        send(ALU_SLT,  16'h8000, 16'h0001, 3'd4, 16'h0001, 0, 0, 1);
        send(ALU_SLT,  16'h7FFF, 16'h8000, 3'd5, 16'h0000, 1, 0, 1);
        send(ALU_NOR,  16'h00F0, 16'h0F00, 3'd6, 16'hF00F, 0, 0, 0);
        send(ALU_NAND, 16'hFFFF, 16'h00FF, 3'd7, 16'hFF00, 0, 0, 0);
        send(ALU_AND,  16'hF0F0, 16'hFF00, 3'd0, 16'hF000, 0, 0, 0);
        send(ALU_OR,   16'h00F0, 16'h0F00, 3'd1, 16'h0FF0, 0, 0, 0);
        send(ALU_XOR,  16'hFFFF, 16'hFFFF, 3'd2, 16'h0000, 1, 0, 0);
        send(ALU_SUB,  16'h8000, 16'h0001, 3'd3, 16'h7FFF, 0, 1, 1);
        send(ALU_AND,  16'h1234, 16'h0000, 3'd4, 16'h0000, 1, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("alu_drained", sb.size(), 32'd0);

        accepted = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(ALU_ADD, 16'(i), 16'h0100, 3'(i),
                         16'h0100 + 16'(i), 0, 0, 0);
            end
            begin
                int n;
                n = 0;
                while (accepted < 2 && n < 100) begin
                    @(posedge clk);
                    #2;
                    n++;
                end
                check("stream_reach_beat2", accepted, 32'd2);
                out_ready = 1'b0;
                check("stream_ready_still_high",
                      {31'b0, in_ready}, 32'd1);
                @(posedge clk);
                #2;
                check("stream_ready_drop", {31'b0, in_ready}, 32'd0);
                check("stream_hold_tag", {29'b0, out_tag}, 32'd1);
                repeat (2) @(posedge clk);
                #2;
                check("stream_ready_still_low",
                      {31'b0, in_ready}, 32'd0);
                check("stream_hold_result", {16'b0, out_result},
                      32'h0101);
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("stream_drained", sb.size(), 32'd0);

        out_ready = 1'b0;
        send(ALU_ADD, 16'h0001, 16'h0001, 3'd1, 16'h0002, 0, 0, 0);
        send(ALU_ADD, 16'h0002, 16'h0002, 3'd2, 16'h0004, 0, 0, 0);
        check("flush_skid_full_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_x     = 16'h0003;
        in_y     = 16'h0003;
        in_op    = ALU_ADD;
        in_tag   = 3'd3;
        flush    = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("flush_no_drain", {31'b0, out_valid}, 32'd0);
        end

        out_ready = 1'b0;
        send(ALU_ADD, 16'h0001, 16'h0001, 3'd6, 16'h0002, 0, 0, 0);
        check("mrst_pre_valid", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mrst_result", {16'b0, out_result}, 32'd0);
        check("mrst_tag", {29'b0, out_tag}, 32'd0);
        check("mrst_flags", {29'b0, out_zero, out_carry, out_ovf}, 32'd0);
        check("mrst_in_ready", {31'b0, in_ready}, 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_release_ready", {31'b0, in_ready}, 32'd1);
        check("mrst_release_valid", {31'b0, out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("final_sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
